// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding, default width
// and the two's-complement negate helper used for sign fix-up.
package div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [DEF_WIDTH-1:0] negate(input logic [DEF_WIDTH-1:0] x);
        return ~x + DEF_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, trial-subtract the divisor.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is consumed.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        // Extra top bit acts as the borrow: set means the divisor did not fit.
        trial   = rem_sh + ~{1'b0, divisor} + (WIDTH+1)'(1);
        rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/div32_iter.sv
// Multicycle signed divider: quotient truncated toward zero, remainder signed like the dividend.
// Latency WIDTH+2 edges from start to ready pulse; divide-by-zero completes after 2 edges.
// No backpressure: starts while busy are dropped, results are a one-cycle ready pulse.
module div32_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               exc_pend_q, exc_pend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   step_rem, step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        exc_pend_d  = exc_pend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_div) begin
                    sign_a_d  = data_operandA[WIDTH-1];
                    sign_b_d  = data_operandB[WIDTH-1];
                    divisor_d = data_operandB[WIDTH-1] ? negate(data_operandB) : data_operandB;
                    rem_d     = '0;
                    cnt_d     = '0;
                    exc_d     = 1'b0;
                    if (data_operandB == '0) begin
                        exc_pend_d = 1'b1;
                        quo_d      = '0;
                        state_d    = S_DONE;
                    end else begin
                        exc_pend_d = 1'b0;
                        quo_d      = data_operandA[WIDTH-1] ? negate(data_operandA) : data_operandA;
                        state_d    = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d    = exc_pend_q ? '0 :
                              ((sign_a_q ^ sign_b_q) ? negate(quo_q) : quo_q);
                remainder_d = exc_pend_q ? '0 : (sign_a_q ? negate(rem_q) : rem_q);
                exc_d       = exc_pend_q;
                rdy_d       = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Busy stays up through the ready cycle so the stage sees one continuous stall.
        busy_d = (state_d != S_IDLE) || rdy_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            exc_pend_q  <= 1'b0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            exc_pend_q  <= exc_pend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div32_iter.sv
// Bench for div32_iter: directed vector table, multi-cycle corner sequences and a
// randomized scoreboard against a 64-bit arithmetic reference.
module tb_div32_iter;

    logic        clock;
    logic        reset;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    div32_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating signed division done in 64-bit arithmetic, so -2^31/-1 just wraps.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; e = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            e  = 1'b0;
        end
    endtask

    // Issue a start, then watch ncyc cycles (index i = sample after edge i).
    // inj: cycle at which a stray 9/3 start is pulsed; rst_at: cycle at which reset is pulsed.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sync,
                         input int inj, input int rst_at, input int ncyc,
                         output int lat, output int npulse,
                         output logic [31:0] r_q, output logic [31:0] r_r, output logic r_e,
                         output logic [31:0] h_q, output logic [31:0] h_r, output logic h_e,
                         output int busy_err);
        if (sync) @(negedge clock);
        ctrl_div = 1'b1;
        data_operandA = a;
        data_operandB = b;
        lat = -1; npulse = 0; busy_err = 0;
        r_q = 'x; r_r = 'x; r_e = 1'bx;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            ctrl_div = (i == inj);
            if (i == inj) begin
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end
            reset = (i == rst_at);
            if (data_resultRDY === 1'b1) begin
                npulse++;
                if (lat < 0) begin
                    lat = i;
                    r_q = data_result;
                    r_r = data_remainder;
                    r_e = data_exception;
                end
            end
            if (busy !== ((lat < 0) || (lat == i))) busy_err++;
        end
        ctrl_div = 1'b0;
        reset    = 1'b0;
        h_q = data_result;
        h_r = data_remainder;
        h_e = data_exception;
    endtask

    initial begin
        int lat, np, berr;
        logic [31:0] rq, rr, hq, hr, eq, er;
        logic re, he, ee;
        logic [31:0] ra, rb;

        vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
        vecs[3]  = '{32'd5,         32'd0,         32'd0,         32'd0,         1'b1};
        vecs[4]  = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
        vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[6]  = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0,         1'b0};
        vecs[7]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        vecs[8]  = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[9]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0};
        vecs[10] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0};
        vecs[11] = '{32'd1,         32'h80000000,  32'd0,         32'd1,         1'b0};

        reset = 1'b1; ctrl_div = 1'b0; data_operandA = '0; data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {data_result, data_remainder},  64'd0);
        chk("reset_flags",   {data_exception, data_resultRDY, busy}, 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            do_op(vecs[k].a, vecs[k].b, 1'b1, -1, -1, 35, lat, np, rq, rr, re, hq, hr, he, berr);
            chk($sformatf("tbl%0d_quo", k), rq, vecs[k].q);
            chk($sformatf("tbl%0d_rem", k), rr, vecs[k].r);
            chk($sformatf("tbl%0d_exc", k), re, vecs[k].e);
            chk($sformatf("tbl%0d_lat", k), lat, vecs[k].e ? 1 : 33);
            chk($sformatf("tbl%0d_pulses", k), np, 1);
            chk($sformatf("tbl%0d_busy", k), berr, 0);
            chk($sformatf("tbl%0d_hold", k), {hq, hr, he}, {vecs[k].q, vecs[k].r, vecs[k].e});
        end

        // Stray start in RUN must be ignored.
        do_op(32'd1000, 32'd10, 1'b1, 4, -1, 35, lat, np, rq, rr, re, hq, hr, he, berr);
        chk("ignore_quo", rq, 32'd100);
        chk("ignore_lat", lat, 33);
        chk("ignore_pulses", np, 1);
        chk("ignore_busy", berr, 0);

        // Reset mid-run abandons the op and clears outputs.
        do_op(32'd50, 32'd5, 1'b1, -1, 9, 35, lat, np, rq, rr, re, hq, hr, he, berr);
        chk("midrst_pulses", np, 0);
        chk("midrst_outputs", {hq, hr, he, busy}, 64'd0);
        do_op(32'd50, 32'd5, 1'b1, -1, -1, 35, lat, np, rq, rr, re, hq, hr, he, berr);
        chk("after_rst_quo", {rq, rr}, {32'd10, 32'd0});
        chk("after_rst_lat", lat, 33);

        // Reset together with start: reset wins, nothing runs.
        @(negedge clock);
        reset = 1'b1; ctrl_div = 1'b1; data_operandA = 32'd77; data_operandB = 32'd7;
        @(negedge clock);
        reset = 1'b0; ctrl_div = 1'b0;
        np = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1 || busy === 1'b1) np++;
        end
        chk("rst_vs_start", np, 0);

        // Back-to-back: new start in the idle cycle where the ready pulse is high.
        do_op(32'd100, 32'd7, 1'b1, -1, -1, 33, lat, np, rq, rr, re, hq, hr, he, berr);
        @(negedge clock);
        chk("b2b_first_rdy", {data_resultRDY, data_result}, {1'b1, 32'd14});
        do_op(32'd9, 32'd3, 1'b0, -1, -1, 35, lat, np, rq, rr, re, hq, hr, he, berr);
        chk("b2b_second", {rq, rr, re}, {32'd3, 32'd0, 1'b0});
        chk("b2b_second_lat", lat, 33);

        // Randomized scoreboard with a bias toward the awkward operands.
        for (int n = 0; n < 1500; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = -($urandom_range(1, 15));
                3: begin rb = 32'hFFFFFFFF; ra = 32'h80000000; end
                4: rb = 32'h80000000;
                5: ra = $urandom_range(0, 100);
                default: rb = $urandom;
            endcase
            ref_div(ra, rb, eq, er, ee);
            do_op(ra, rb, 1'b1, -1, -1, 35, lat, np, rq, rr, re, hq, hr, he, berr);
            chk($sformatf("rand_%h_%h_qr", ra, rb), {rq, rr}, {eq, er});
            chk($sformatf("rand_%h_%h_exc_lat", ra, rb), {re, 32'(lat)}, {ee, (ee ? 32'd1 : 32'd33)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
